// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings for the bridge test environment.
//   size_t        HSIZE encoding (bytes = 2**HSIZE)
//   burst_t       HBURST encoding (carried on the bus, not interpreted by the memory)
//   state_t       HTRANS encoding (IDLE/BUSY/NONSEQ/SEQ)
//   response_t    HRESP encoding (OKAY/ERROR)
//   slave_state_t data-phase FSM of the memory responder
//   size_bytes()  number of bytes moved by one transfer of a given size
//
// Handshake: a transfer's address phase is accepted on a rising edge where
// HREADY=1 and HTRANS is NONSEQ or SEQ; its data phase ends on the next rising
// edge where HREADY=1. Nothing else constitutes a handshake.
package ahb_pkg;

    typedef enum logic [2:0] {
        SIZE_BYTE   = 3'd0,
        SIZE_HALF   = 3'd1,
        SIZE_WORD   = 3'd2,
        SIZE_DWORD  = 3'd3,
        SIZE_4WORD  = 3'd4,
        SIZE_8WORD  = 3'd5,
        SIZE_16WORD = 3'd6,
        SIZE_32WORD = 3'd7
    } size_t;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2,
        BURST_INCR4  = 3'd3,
        BURST_WRAP8  = 3'd4,
        BURST_INCR8  = 3'd5,
        BURST_WRAP16 = 3'd6,
        BURST_INCR16 = 3'd7
    } burst_t;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } state_t;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } response_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_LAST = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } slave_state_t;

    function automatic int unsigned size_bytes(size_t size);
        return 32'd1 << size;
    endfunction

endpackage

// File: rtl/ahb_byte_lanes.sv
// ahb_byte_lanes: combinational byte-lane enable generator.
//   addr_lo  in   low address bits selecting the first lane inside the bus word
//   size     in   HSIZE of the transfer
//   lanes    out  one enable per byte lane, set for [addr_lo, addr_lo + 2**size - 1]
// Sizes wider than the bus are illegal elsewhere; here they simply saturate
// to the lanes that exist.
module ahb_byte_lanes
    import ahb_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [$clog2(DATA_WIDTH/8)-1:0] addr_lo,
    input  logic [2:0]                      size,
    output logic [DATA_WIDTH/8-1:0]         lanes
);

    localparam int LANES = DATA_WIDTH / 8;

    always_comb begin
        int unsigned lo_lane;
        int unsigned hi_lane;
        lo_lane = 32'(addr_lo);
        hi_lane = lo_lane + size_bytes(size_t'(size)) - 32'd1;
        lanes   = '0;
        for (int i = 0; i < LANES; i++) begin
            lanes[i] = (32'(i) >= lo_lane) && (32'(i) <= hi_lane);
        end
    end

endmodule

// File: rtl/ahb_s_mem.sv
// ahb_s_mem: AHB-Lite memory responder backed by a byte-addressable array.
//   HCLK, HRESETn  clock (rising edge) and asynchronous active-low reset
//   HADDR, HWRITE, HSIZE, HBURST, HTRANS  address-phase inputs
//   HWDATA         write data, valid during the data phase
//   HREADY         registered; low during inserted wait states and ERROR cycle 1
//   HRESP          registered; high for both cycles of an ERROR response
//   HRDATA         registered read data, valid in the final data-phase cycle,
//                  inactive lanes forced to zero, held otherwise
// Every legal transfer gets WAIT_CYCLES wait states followed by one ready
// cycle. Out-of-range, misaligned or over-wide transfers get a two-cycle
// ERROR response and never touch memory.
module ahb_s_mem
    import ahb_pkg::*;
#(
    parameter int AHB_DATA_WIDTH    = 64,
    parameter int AHB_ADDRESS_WIDTH = 32,
    parameter int MEM_BYTES         = 1024,
    parameter int WAIT_CYCLES       = 0
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic [AHB_ADDRESS_WIDTH-1:0] HADDR,
    input  logic [AHB_DATA_WIDTH-1:0]    HWDATA,
    input  logic                         HWRITE,
    input  logic [2:0]                   HSIZE,
    input  logic [2:0]                   HBURST,
    input  logic [1:0]                   HTRANS,
    output logic                         HREADY,
    output logic                         HRESP,
    output logic [AHB_DATA_WIDTH-1:0]    HRDATA
);

    localparam int LANES = AHB_DATA_WIDTH / 8;
    localparam int LW    = $clog2(LANES);
    localparam int MW    = $clog2(MEM_BYTES);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    slave_state_t state;
    slave_state_t state_next;
    logic [3:0]   wait_cnt;

    // Address phase captured for the transfer now in its data phase.
    logic [MW-1:0] a_addr;
    logic          a_write;
    logic [2:0]    a_size;

    logic [7:0] mem [MEM_BYTES];

    logic                      sample;
    logic                      illegal;
    logic                      commit;
    logic                      rd_from_bus;
    logic                      load_rd;
    logic [LANES-1:0]          bus_lanes;
    logic [LANES-1:0]          pend_lanes;
    logic [LANES-1:0]          rd_lanes;
    logic [MW-LW-1:0]          pend_base;
    logic [MW-LW-1:0]          rd_base;
    logic [AHB_DATA_WIDTH-1:0] rd_data;

    // HBURST is carried for bus completeness only.
    logic unused_burst;
    assign unused_burst = ^HBURST;

    ahb_byte_lanes #(.DATA_WIDTH(AHB_DATA_WIDTH)) u_bus_lanes (
        .addr_lo (HADDR[LW-1:0]),
        .size    (HSIZE),
        .lanes   (bus_lanes)
    );

    ahb_byte_lanes #(.DATA_WIDTH(AHB_DATA_WIDTH)) u_pend_lanes (
        .addr_lo (a_addr[LW-1:0]),
        .size    (a_size),
        .lanes   (pend_lanes)
    );

    assign sample = HREADY && ((HTRANS == TRANS_NONSEQ) || (HTRANS == TRANS_SEQ));

    always_comb begin
        int unsigned nbytes;
        nbytes  = size_bytes(size_t'(HSIZE));
        illegal = ({1'b0, HADDR} >= (AHB_ADDRESS_WIDTH+1)'(MEM_BYTES))
               || ((HADDR & AHB_ADDRESS_WIDTH'(nbytes - 32'd1)) != '0)
               || (nbytes > 32'(LANES));
    end

    // S_IDLE, S_LAST and S_ERR2 all drive HREADY=1, so each of them doubles
    // as the address-phase cycle of the next transfer.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_LAST, S_ERR2: begin
                if (!sample)
                    state_next = S_IDLE;
                else if (illegal)
                    state_next = S_ERR1;
                else if (WAIT_CYCLES > 0)
                    state_next = S_WAIT;
                else
                    state_next = S_LAST;
            end
            S_WAIT: begin
                if (wait_cnt <= 4'd1)
                    state_next = S_LAST;
            end
            S_ERR1:  state_next = S_ERR2;
            default: state_next = S_IDLE;
        endcase
    end

    assign commit    = (state == S_LAST) && a_write;
    assign pend_base = a_addr[MW-1:LW];

    // HRDATA is loaded on the edge that enters S_LAST. With no wait states
    // that edge is the address sample itself, so the address comes straight
    // off the bus; after wait states it comes from the captured phase.
    assign rd_from_bus = (state != S_WAIT);
    assign load_rd     = (state_next == S_LAST) && (rd_from_bus ? !HWRITE : !a_write);
    assign rd_lanes    = rd_from_bus ? bus_lanes : pend_lanes;
    assign rd_base     = rd_from_bus ? HADDR[MW-1:LW] : a_addr[MW-1:LW];

    // A write committing on the same edge as this load has not reached the
    // array yet, so its bytes are taken from HWDATA instead.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (rd_lanes[i]) begin
                if (commit && pend_lanes[i] && (rd_base == pend_base))
                    rd_data[8*i +: 8] = HWDATA[8*i +: 8];
                else
                    rd_data[8*i +: 8] = mem[{rd_base, LW'(i)}];
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            a_addr   <= '0;
            a_write  <= 1'b0;
            a_size   <= '0;
            HREADY   <= 1'b1;
            HRESP    <= RESP_OKAY;
            HRDATA   <= '0;
        end else begin
            state  <= state_next;
            HREADY <= !((state_next == S_WAIT) || (state_next == S_ERR1));
            HRESP  <= ((state_next == S_ERR1) || (state_next == S_ERR2)) ? RESP_ERROR : RESP_OKAY;

            if (state_next == S_WAIT)
                wait_cnt <= (state == S_WAIT) ? wait_cnt - 4'd1 : WAIT_LOAD;
            else
                wait_cnt <= '0;

            if (sample && !illegal) begin
                a_addr  <= HADDR[MW-1:0];
                a_write <= HWRITE;
                a_size  <= HSIZE;
            end else if (state == S_LAST) begin
                // Pending phase has completed; make sure it cannot commit twice.
                a_write <= 1'b0;
            end

            if (load_rd)
                HRDATA <= rd_data;
        end
    end

    // Array has no reset; commits only happen in S_LAST, which reset leaves.
    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int i = 0; i < LANES; i++) begin
                if (pend_lanes[i])
                    mem[{pend_base, LW'(i)}] <= HWDATA[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_s_mem.sv
// tb_ahb_s_mem: directed bench for ahb_s_mem. Two instances share the bus
// inputs: u_dut0 with no wait states and u_dut1 with two. Only the selected
// instance sees non-IDLE HTRANS, and the driver follows that instance's HREADY.
module tb_ahb_s_mem;

    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_BUSY   = 2'd1;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;
    localparam int         MAX_SLOTS = 32;

    // ---------------- clock / reset / bus signals ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] haddr;
    logic [63:0] hwdata;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [1:0]  htrans;
    logic        sel;

    logic [1:0]  htrans0, htrans1;
    logic        hready0, hready1, hresp0, hresp1;
    logic [63:0] hrdata0, hrdata1;
    logic        bus_ready, bus_resp;
    logic [63:0] bus_rdata;

    always #5 clk = ~clk;

    assign htrans0   = sel ? TR_IDLE : htrans;
    assign htrans1   = sel ? htrans : TR_IDLE;
    assign bus_ready = sel ? hready1 : hready0;
    assign bus_resp  = sel ? hresp1  : hresp0;
    assign bus_rdata = sel ? hrdata1 : hrdata0;

    ahb_s_mem #(.AHB_DATA_WIDTH(64), .AHB_ADDRESS_WIDTH(32), .MEM_BYTES(1024), .WAIT_CYCLES(0)) u_dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr), .HWDATA(hwdata), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans0),
        .HREADY(hready0), .HRESP(hresp0), .HRDATA(hrdata0)
    );

    ahb_s_mem #(.AHB_DATA_WIDTH(64), .AHB_ADDRESS_WIDTH(32), .MEM_BYTES(1024), .WAIT_CYCLES(2)) u_dut1 (
        .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr), .HWDATA(hwdata), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans1),
        .HREADY(hready1), .HRESP(hresp1), .HRDATA(hrdata1)
    );

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- transfer slots ----------------
    int          ns;
    logic [1:0]  s_trans [MAX_SLOTS];
    logic        s_write [MAX_SLOTS];
    logic [2:0]  s_size  [MAX_SLOTS];
    logic [31:0] s_addr  [MAX_SLOTS];
    logic [63:0] s_wdata [MAX_SLOTS];

    int          r_waits      [MAX_SLOTS];
    logic        r_resp_first [MAX_SLOTS];
    logic        r_resp_last  [MAX_SLOTS];
    logic [63:0] r_rdata_first[MAX_SLOTS];
    logic [63:0] r_rdata      [MAX_SLOTS];

    task automatic add(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                       input logic [31:0] ad, input logic [63:0] wd);
        s_trans[ns] = tr;
        s_write[ns] = wr;
        s_size[ns]  = sz;
        s_addr[ns]  = ad;
        s_wdata[ns] = wd;
        ns++;
    endtask

    task automatic present(input int idx);
        if (idx < ns) begin
            htrans = s_trans[idx];
            hwrite = s_write[idx];
            hsize  = s_size[idx];
            haddr  = s_addr[idx];
        end else begin
            htrans = TR_IDLE;
            hwrite = 1'b0;
            hsize  = 3'd0;
            haddr  = 32'd0;
        end
    endtask

    // Pipelined driver: address of slot cur overlaps the data phase of slot dp.
    task automatic run_seq(input string tag);
        int   cur;
        int   dp;
        int   guard;
        logic rdy;
        logic first_seen [MAX_SLOTS];
        cur   = 0;
        dp    = -1;
        guard = 0;
        for (int k = 0; k < MAX_SLOTS; k++) begin
            r_waits[k]    = 0;
            first_seen[k] = 1'b0;
        end
        present(cur);
        while ((cur < ns || dp >= 0) && guard < 200) begin
            @(negedge clk);
            guard++;
            rdy = bus_ready;
            if (dp >= 0) begin
                if (!first_seen[dp]) begin
                    first_seen[dp]    = 1'b1;
                    r_resp_first[dp]  = bus_resp;
                    r_rdata_first[dp] = bus_rdata;
                end
                if (!rdy) begin
                    r_waits[dp]++;
                end else begin
                    r_resp_last[dp] = bus_resp;
                    r_rdata[dp]     = bus_rdata;
                end
            end
            @(posedge clk);
            #1;
            if (rdy) begin
                if (cur < ns) begin
                    dp = cur;
                    cur++;
                end else begin
                    dp = -1;
                end
                present(cur);
                hwdata = (dp >= 0) ? s_wdata[dp] : 64'd0;
            end
        end
        chk({tag, "_done"}, 64'((cur >= ns) && (dp < 0)), 64'd1);
    endtask

    function automatic int sum_waits(input int from, input int to);
        int s;
        s = 0;
        for (int k = from; k <= to; k++) s += r_waits[k];
        return s;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst_n  = 1'b0;
        sel    = 1'b0;
        haddr  = '0;
        hwdata = '0;
        hwrite = 1'b0;
        hsize  = 3'd0;
        hburst = 3'd0;
        htrans = TR_IDLE;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", 64'(hready0), 64'd1);
        chk("rst_resp0",  64'(hresp0),  64'd0);
        chk("rst_rdata0", hrdata0,      64'd0);
        chk("rst_ready1", 64'(hready1), 64'd1);
        chk("rst_resp1",  64'(hresp1),  64'd0);
        chk("rst_rdata1", hrdata1,      64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: INCR4 word writes then INCR4 word reads, zero wait states
        hburst = 3'd3;
        ns = 0;
        add(TR_NONSEQ, 1'b1, 3'd2, 32'h0, {2{32'h03020100}});
        add(TR_SEQ,    1'b1, 3'd2, 32'h4, {2{32'h07060504}});
        add(TR_SEQ,    1'b1, 3'd2, 32'h8, {2{32'h0B0A0908}});
        add(TR_SEQ,    1'b1, 3'd2, 32'hC, {2{32'h0F0E0D0C}});
        add(TR_NONSEQ, 1'b0, 3'd2, 32'h0, 64'd0);
        add(TR_SEQ,    1'b0, 3'd2, 32'h4, 64'd0);
        add(TR_SEQ,    1'b0, 3'd2, 32'h8, 64'd0);
        add(TR_SEQ,    1'b0, 3'd2, 32'hC, 64'd0);
        run_seq("t1");
        chk("t1_waits",  64'(sum_waits(0, 7)), 64'd0);
        chk("t1_rd0",    r_rdata[4], 64'h0000_0000_0302_0100);
        chk("t1_rd4",    r_rdata[5], 64'h0706_0504_0000_0000);
        chk("t1_rd8",    r_rdata[6], 64'h0000_0000_0B0A_0908);
        chk("t1_rdC",    r_rdata[7], 64'h0F0E_0D0C_0000_0000);
        chk("t1_resp",   64'(r_resp_last[7] | r_resp_last[4]), 64'd0);

        // 3: halfword write at 0x2 then back-to-back word read at 0x0
        hburst = 3'd0;
        ns = 0;
        add(TR_NONSEQ, 1'b1, 3'd1, 32'h2, {4{16'hBEEF}});
        add(TR_NONSEQ, 1'b0, 3'd2, 32'h0, 64'd0);
        run_seq("t3");
        chk("t3_waits", 64'(sum_waits(0, 1)), 64'd0);
        chk("t3_fwd",   r_rdata[1], 64'h0000_0000_BEEF_0100);

        // 4: out of range, misaligned, over-wide, then a legal read
        ns = 0;
        add(TR_NONSEQ, 1'b1, 3'd2, 32'h400, {2{32'hDEADDEAD}});
        add(TR_NONSEQ, 1'b1, 3'd2, 32'h2,   {2{32'hDEADDEAD}});
        add(TR_NONSEQ, 1'b0, 3'd4, 32'h0,   64'd0);
        add(TR_NONSEQ, 1'b0, 3'd3, 32'h0,   64'd0);
        run_seq("t4");
        chk("t4_range_waits", 64'(r_waits[0]), 64'd1);
        chk("t4_range_resp1", 64'(r_resp_first[0]), 64'd1);
        chk("t4_range_resp2", 64'(r_resp_last[0]), 64'd1);
        chk("t4_align_waits", 64'(r_waits[1]), 64'd1);
        chk("t4_align_resp1", 64'(r_resp_first[1]), 64'd1);
        chk("t4_align_resp2", 64'(r_resp_last[1]), 64'd1);
        chk("t4_wide_waits",  64'(r_waits[2]), 64'd1);
        chk("t4_wide_resp1",  64'(r_resp_first[2]), 64'd1);
        chk("t4_wide_resp2",  64'(r_resp_last[2]), 64'd1);
        chk("t4_after_waits", 64'(r_waits[3]), 64'd0);
        chk("t4_after_resp",  64'(r_resp_last[3]), 64'd0);
        chk("t4_after_data",  r_rdata[3], 64'h0706_0504_BEEF_0100);

        // 5: INCR8 doubleword writes with a BUSY after beat 2, then INCR8 reads
        hburst = 3'd5;
        ns = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 3)
                add(TR_BUSY, 1'b1, 3'd3, 32'h38, 64'hFFFF_FFFF_FFFF_FFFF);
            add((k == 0) ? TR_NONSEQ : TR_SEQ, 1'b1, 3'd3, 32'h20 + 32'(8*k),
                {32'hC0DE_0000 + 32'(k), 32'h5A5A_0000 + 32'(k)});
        end
        run_seq("t5w");
        chk("t5_busy_waits", 64'(r_waits[3]), 64'd0);
        chk("t5_busy_resp",  64'(r_resp_last[3]), 64'd0);
        chk("t5_wr_waits",   64'(sum_waits(0, 8)), 64'd0);
        ns = 0;
        for (int k = 0; k < 8; k++)
            add((k == 0) ? TR_NONSEQ : TR_SEQ, 1'b0, 3'd3, 32'h20 + 32'(8*k), 64'd0);
        run_seq("t5r");
        for (int k = 0; k < 8; k++)
            chk($sformatf("t5_rd%0d", k), r_rdata[k], {32'hC0DE_0000 + 32'(k), 32'h5A5A_0000 + 32'(k)});

        // 2: two wait states, doubleword write then read at 0x8
        hburst = 3'd0;
        sel = 1'b1;
        ns = 0;
        add(TR_NONSEQ, 1'b1, 3'd3, 32'h8, 64'h1122_3344_5566_7788);
        add(TR_NONSEQ, 1'b0, 3'd3, 32'h8, 64'd0);
        run_seq("t2");
        chk("t2_wr_waits",  64'(r_waits[0]), 64'd2);
        chk("t2_rd_waits",  64'(r_waits[1]), 64'd2);
        chk("t2_rd_early",  r_rdata_first[1], 64'd0);
        chk("t2_rd_resp",   64'(r_resp_last[1]), 64'd0);
        chk("t2_rd_data",   r_rdata[1], 64'h1122_3344_5566_7788);

        // 6: reset during the wait states of a write to 0x10
        ns = 0;
        add(TR_NONSEQ, 1'b1, 3'd3, 32'h10, 64'hA5A5_0000_1111_2222);
        run_seq("t6old");
        @(posedge clk);
        #1;
        htrans = TR_NONSEQ;
        hwrite = 1'b1;
        haddr  = 32'h10;
        hsize  = 3'd3;
        @(posedge clk);
        #1;
        htrans = TR_IDLE;
        hwrite = 1'b0;
        hwdata = 64'hDEAD_BEEF_0BAD_F00D;
        @(negedge clk);
        chk("t6_in_wait", 64'(bus_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ready", 64'(bus_ready), 64'd1);
        chk("t6_rst_resp",  64'(bus_resp),  64'd0);
        chk("t6_rst_rdata", bus_rdata,      64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ns = 0;
        add(TR_NONSEQ, 1'b0, 3'd3, 32'h10, 64'd0);
        run_seq("t6rd");
        chk("t6_rd_waits", 64'(r_waits[0]), 64'd2);
        chk("t6_old_data", r_rdata[0], 64'hA5A5_0000_1111_2222);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
